// File: rtl/gpu_rect_fill_pkg.sv
// Shared definitions for the rectangle-fill engine.
//   - register byte offsets inside the slave register window
//   - fill state encoding
//   - framebuffer word stride
//   - clip_len(): clip a span [pos, pos+len) against a screen dimension
package gpu_rect_fill_pkg;

  localparam logic [3:0] OFF_CTRL  = 4'h0;
  localparam logic [3:0] OFF_DST   = 4'h4;
  localparam logic [3:0] OFF_SIZE  = 4'h8;
  localparam logic [3:0] OFF_COLOR = 4'hC;

  localparam int unsigned FB_STRIDE = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RUN,
    ST_DRAIN
  } fill_state_e;

  // Visible length of a span starting at pos with length len on an axis of lim pixels.
  function automatic logic [15:0] clip_len(input logic [15:0] pos, input logic [15:0] len,
                                           input int unsigned lim);
    logic [31:0] rem;
    if (32'(pos) >= lim) return '0;
    rem = lim - 32'(pos);
    return (32'(len) < rem) ? len : rem[15:0];
  endfunction

endpackage

// File: rtl/gpu_rect_fill_if.sv
// Single-word ICB bus (command + response channel).
//   master modport: drives cmd_*, rsp_rdy; receives cmd_rdy, rsp_*
//   slave  modport: the mirror image
interface gpu_rect_fill_if;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic [31:0] cmd_addr;
  logic        cmd_read;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output cmd_vld, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_rdy,
    input  cmd_rdy, rsp_vld, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_vld, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_rdy,
    output cmd_rdy, rsp_vld, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/gpu_rect_walker.sv
// Walks a clipped rectangle in raster order and produces pixel word addresses.
//   clk, rst      clock, synchronous active-high reset
//   load          latch origin (x,y) and clipped size (cw,ch), restart at pixel 0
//   advance       step to the next pixel
//   x, y, cw, ch  origin and clipped width/height (sampled on load)
//   addr          framebuffer word address of the current pixel
//   last          current pixel is the final one of the rectangle
module gpu_rect_walker
  import gpu_rect_fill_pkg::*;
#(
  parameter int unsigned SCR_W   = 640,
  parameter logic [31:0] FB_BASE = 32'ha1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] cw,
  input  logic [15:0] ch,
  output logic [31:0] addr,
  output logic        last
);

  logic [15:0] col, row, cw_r, ch_r;
  logic [31:0] row_addr;
  logic        col_end;

  assign col_end = (col == cw_r - 16'd1);
  assign last    = col_end && (row == ch_r - 16'd1);
  assign addr    = row_addr + 32'(FB_STRIDE) * 32'(col);

  always_ff @(posedge clk) begin
    if (rst) begin
      col      <= '0;
      row      <= '0;
      cw_r     <= '0;
      ch_r     <= '0;
      row_addr <= '0;
    end else if (load) begin
      col      <= '0;
      row      <= '0;
      cw_r     <= cw;
      ch_r     <= ch;
      row_addr <= FB_BASE + 32'(FB_STRIDE) * (32'(y) * 32'(SCR_W) + 32'(x));
    end else if (advance) begin
      if (col_end) begin
        // Row start advances by one screen line instead of recomputing y*SCR_W.
        col      <= '0;
        row      <= row + 16'd1;
        row_addr <= row_addr + 32'(FB_STRIDE * SCR_W);
      end else begin
        col <= col + 16'd1;
      end
    end
  end

endmodule

// File: rtl/gpu_rect_fill.sv
// Rectangle-fill engine: CPU programs DST/SIZE/COLOR over an ICB slave window,
// writes START, and the engine streams clipped single-pixel writes into the
// framebuffer over an ICB master port.
//   clk, rst  clock, synchronous active-high reset
//   s_icb     slave register window (CTRL/DST/SIZE/COLOR at REG_BASE)
//   m_icb     master write stream to FB_BASE + 4*pixel index
//   done      one-cycle pulse when a fill completes
`ifndef SCREEN_W
`define SCREEN_W 640
`endif
`ifndef SCREEN_H
`define SCREEN_H 480
`endif

module gpu_rect_fill
  import gpu_rect_fill_pkg::*;
#(
  parameter int unsigned SCR_W    = `SCREEN_W,
  parameter int unsigned SCR_H    = `SCREEN_H,
  parameter logic [31:0] REG_BASE = 32'ha0000200,
  parameter logic [31:0] FB_BASE  = 32'ha1000000,
  parameter int unsigned OUTST    = 4
) (
  input  logic            clk,
  input  logic            rst,
  gpu_rect_fill_if.slave  s_icb,
  gpu_rect_fill_if.master m_icb,
  output logic            done
);

  localparam int unsigned OW = $clog2(OUTST + 1);

  fill_state_e state, state_nx;

  logic [15:0]   dst_x, dst_y, size_w, size_h, clip_w, clip_h;
  logic [23:0]   color;
  logic          err, busy, start, done_nx;
  logic          s_hs, s_wr, reg_hit;
  logic [31:0]   rd_mux;
  logic [OW-1:0] outst;
  logic          m_vld, m_hs, rsp_live;
  logic          walk_load, walk_adv, walk_last;
  logic [31:0]   walk_addr;
  logic          unused_rdata;

  assign unused_rdata = ^m_icb.rsp_rdata;

  assign busy    = (state != ST_IDLE);
  assign reg_hit = (s_icb.cmd_addr[31:4] == REG_BASE[31:4]);
  assign s_hs    = s_icb.cmd_vld & s_icb.cmd_rdy;
  assign s_wr    = s_hs & ~s_icb.cmd_read & (s_icb.cmd_wmask == 4'hf) & reg_hit;
  assign start   = s_wr & (s_icb.cmd_addr[3:0] == OFF_CTRL) & s_icb.cmd_wdata[0] & ~busy;

  // Slave register window
  assign s_icb.cmd_rdy = ~s_icb.rsp_vld | s_icb.rsp_rdy;
  assign s_icb.rsp_err = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      dst_x  <= '0;
      dst_y  <= '0;
      size_w <= '0;
      size_h <= '0;
      color  <= '0;
    end else if (s_wr && !busy) begin
      unique case (s_icb.cmd_addr[3:0])
        OFF_DST:   {dst_y, dst_x}   <= s_icb.cmd_wdata;
        OFF_SIZE:  {size_h, size_w} <= s_icb.cmd_wdata;
        OFF_COLOR: color            <= s_icb.cmd_wdata[23:0];
        default:   ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    if (reg_hit) begin
      unique case (s_icb.cmd_addr[3:0])
        OFF_CTRL:  rd_mux = {30'd0, err, busy};
        OFF_DST:   rd_mux = {dst_y, dst_x};
        OFF_SIZE:  rd_mux = {size_h, size_w};
        OFF_COLOR: rd_mux = {8'd0, color};
        default:   rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_icb.rsp_vld   <= 1'b0;
      s_icb.rsp_rdata <= '0;
    end else if (s_hs) begin
      s_icb.rsp_vld   <= 1'b1;
      s_icb.rsp_rdata <= s_icb.cmd_read ? rd_mux : '0;
    end else if (s_icb.rsp_rdy) begin
      s_icb.rsp_vld   <= 1'b0;
    end
  end

  // Clipping (registers are frozen while busy, so this is stable through SETUP)
  assign clip_w = clip_len(dst_x, size_w, SCR_W);
  assign clip_h = clip_len(dst_y, size_h, SCR_H);

  gpu_rect_walker #(
    .SCR_W   (SCR_W),
    .FB_BASE (FB_BASE)
  ) u_walker (
    .clk     (clk),
    .rst     (rst),
    .load    (walk_load),
    .advance (walk_adv),
    .x       (dst_x),
    .y       (dst_y),
    .cw      (clip_w),
    .ch      (clip_h),
    .addr    (walk_addr),
    .last    (walk_last)
  );

  // Master write stream
  assign m_vld              = (state == ST_RUN) && (32'(outst) < OUTST);
  assign m_hs               = m_vld & m_icb.cmd_rdy;
  // Responses with nothing outstanding belong to a fill cut short by reset.
  assign rsp_live           = m_icb.rsp_vld & (outst != '0);
  assign m_icb.cmd_vld      = m_vld;
  assign m_icb.cmd_addr     = walk_addr;
  assign m_icb.cmd_read     = 1'b0;
  assign m_icb.cmd_wdata    = {8'd0, color};
  assign m_icb.cmd_wmask    = 4'hf;
  assign m_icb.rsp_rdy      = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      outst <= '0;
    end else if (m_hs && !rsp_live) begin
      outst <= outst + 1'b1;
    end else if (!m_hs && rsp_live) begin
      outst <= outst - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (state == ST_SETUP) begin
      err <= 1'b0;
    end else if (rsp_live && m_icb.rsp_err) begin
      err <= 1'b1;
    end
  end

  // Fill FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= done_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    walk_load = 1'b0;
    walk_adv  = 1'b0;
    done_nx   = 1'b0;
    unique case (state)
      ST_IDLE: if (start) state_nx = ST_SETUP;
      ST_SETUP: begin
        walk_load = 1'b1;
        if (clip_w == '0 || clip_h == '0) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
        end else begin
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (m_hs) begin
          walk_adv = 1'b1;
          if (walk_last) state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (outst == '0) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule
